gcd_arbiter: RTL and testbench
==============================

Name: gcd_arbiter

Overview:
Shares one gcd datapath unit between NREQ requesters using round-robin arbitration. For each accepted job it latches the operands, pulses the datapath reset to load them, and waits for the done flag. It then captures the result and returns it to the requester that issued the job. It sits between the requester ports and the single gcd instance and is the only block that drives that instance's operand and reset inputs.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 32, operand and result width in bits
MAX_CYCLES, 1024, watchdog limit in RUN cycles (used only with GCD_TIMEOUT_EN)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  NREQ  per-requester job request
req_ready  out  NREQ  one-hot job accept; asserted only in IDLE, on the granted index
req_a  in  NREQ*WIDTH  operand A; slice i belongs to requester i
req_b  in  NREQ*WIDTH  operand B; slice i belongs to requester i
resp_valid  out  NREQ  one-hot result valid
resp_ready  in  NREQ  per-requester result accept
resp_data  out  WIDTH  result, shared bus, meaningful while any resp_valid bit is high
resp_err  out  1  result is an aborted/timeout result; constant 0 without GCD_TIMEOUT_EN
busy  out  1  high in any state other than IDLE
gcd_n1  out  WIDTH  operand to datapath, held stable from LOAD through end of RUN
gcd_n2  out  WIDTH  operand to datapath, held stable from LOAD through end of RUN
gcd_rst  out  1  active-high datapath load/reset pulse
gcd_out  in  WIDTH  datapath result
gcd_done  in  1  datapath done flag (level)

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; all of req_ready, resp_valid, resp_data, resp_err, busy, gcd_n1, gcd_n2 = 0; gcd_rst=1.
  - Round-robin pointer last_grant = NREQ-1, so requester 0 has first priority after reset.
- IDLE:
  - gcd_rst=0.
  - If any req_valid bit is set, grant the first set index searching from last_grant+1 with wrap-around. Drive req_ready[grant]=1 combinationally in the same cycle.
  - Latch req_a/req_b slices for the grant, update last_grant, then:
    - if either operand is 0, go to RESP with result = the other operand (gcd(0,0)=0), bypassing the datapath;
    - otherwise go to LOAD.
  - Exactly one acceptance per IDLE cycle; non-granted requesters keep req_valid held.
- LOAD (1 cycle): gcd_n1/gcd_n2 = latched operands; gcd_rst=1; then go to RUN.
- RUN:
  - gcd_rst=0.
  - gcd_done is ignored in the first RUN cycle, because it can be stale from the previous job; it is sampled from the second RUN cycle onward.
  - On done, capture gcd_out into resp_data and go to RESP.
- RESP:
  - resp_valid[grant]=1, with resp_data held stable.
  - When resp_ready[grant]=1, clear resp_valid and go to IDLE.
  - resp_ready on other indices is ignored.
- Latency, nonzero operands: accept cycle, then 1 LOAD cycle, then the datapath cycles, then 1 capture edge. resp_valid rises on the edge after done is sampled.
- Back-to-back: a new job is accepted no earlier than the IDLE cycle following the RESP handshake. There is no overlap with a job in flight.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,2,3,0,…
- Simultaneous events: a req_valid drop in the same cycle it would be granted means no grant. A grant needs req_valid high in the IDLE cycle.
- Reset mid-operation: the job is abandoned and no response is issued. gcd_rst is asserted until reset deasserts, which clears the datapath.

Optional Feature:
GCD_TIMEOUT_EN
- Defined: a RUN-cycle counter (width $clog2(MAX_CYCLES)+1) clears in LOAD.
  - If it reaches MAX_CYCLES without done, go to RESP with resp_data=0 and resp_err=1.
  - resp_err clears on the RESP handshake.
- Undefined: no counter is built; RUN waits indefinitely; resp_err is tied to 0.

Decomposition:
- Package gcd_arb_pkg holds:
  - state enum {IDLE, LOAD, RUN, RESP}, 2-bit encoding;
  - default NREQ/WIDTH constants;
  - the MAX_CYCLES default.
- Sub-module rr_pick:
  - combinational round-robin priority picker;
  - inputs: req vector, last_grant;
  - outputs: one-hot grant, grant index, any.

Test Plan:
- Single job: req 0 with a=121, b=11 -> gcd_rst pulses 1 cycle with gcd_n1=121, gcd_n2=11; resp_valid[0]=1, resp_data=11; clears on resp_ready[0].
- Zero bypass: req 2 with a=0, b=36 -> RESP reached with no gcd_rst pulse, resp_data=36. Then a=0, b=0 -> resp_data=0.
- Fairness: all 4 requesters held valid with a=48, b=18 -> grant order 0,1,2,3,0, each returning 6; no requester starved.
- Response backpressure: resp_ready[1] held low for 20 cycles after result 7 (a=35, b=49) -> resp_valid and resp_data stable, busy=1, no new req_ready.
- Mid-job reset: reset driven low during RUN -> all outputs at reset values immediately; after release, first grant goes to requester 0.
- Timeout (GCD_TIMEOUT_EN, MAX_CYCLES=16, gcd_done forced 0) -> after 16 RUN cycles, resp_valid with resp_data=0 and resp_err=1.

Source files
------------

// File: rtl/gcd_arb_pkg.sv
// Shared types and default sizing for the gcd arbiter slice.
package gcd_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam int DEF_NREQ       = 4;
    localparam int DEF_WIDTH      = 32;
    localparam int DEF_MAX_CYCLES = 1024;

endpackage

// File: rtl/gcd_arbiter_if.sv
// Requester-side job/result bundle; the arbiter takes the slave view.
interface gcd_arbiter_if
    import gcd_arb_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int WIDTH = DEF_WIDTH
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       resp_valid;
    logic [NREQ-1:0]       resp_ready;
    logic [WIDTH-1:0]      resp_data;
    logic                  resp_err;

    modport master (
        output req_valid, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_err
    );

    modport slave (
        input  req_valid, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_data, resp_err
    );
endinterface

// File: rtl/gcd_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after last_grant, wrapping.
module rr_pick
    import gcd_arb_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    localparam int IW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last_grant,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx,
    output logic            any
);

    always_comb begin : search
        logic [IW-1:0] cand;
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = last_grant;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = (cand == IW'(NREQ - 1)) ? '0 : cand + 1'b1;
            if (!any && req[cand]) begin
                any       = 1'b1;
                idx       = cand;
                gnt[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gcd_arbiter.sv
// Round-robin front end sharing one gcd datapath between NREQ requesters.
// Define GCD_TIMEOUT_EN to add a RUN-cycle watchdog that returns resp_err=1.
module gcd_arbiter
    import gcd_arb_pkg::*;
#(
    parameter int NREQ       = DEF_NREQ,
    parameter int WIDTH      = DEF_WIDTH,
    parameter int MAX_CYCLES = DEF_MAX_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    gcd_arbiter_if.slave     bus,
    output logic             busy,
    output logic [WIDTH-1:0] gcd_n1,
    output logic [WIDTH-1:0] gcd_n2,
    output logic             gcd_rst,
    input  logic [WIDTH-1:0] gcd_out,
    input  logic             gcd_done
);

    localparam int IW = $clog2(NREQ);

    state_t           state, state_nxt;
    logic [IW-1:0]    last_grant, grant_idx;
    logic [WIDTH-1:0] op_a, op_b, resp_data_q;
    logic             run_armed;

    logic [NREQ-1:0]  pick_gnt;
    logic [IW-1:0]    pick_idx;
    logic             pick_any;
    logic [WIDTH-1:0] a_sel, b_sel;
    logic             accept, zero_op, done_seen, handshake, timeout;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req        (bus.req_valid),
        .last_grant (last_grant),
        .gnt        (pick_gnt),
        .idx        (pick_idx),
        .any        (pick_any)
    );

    assign a_sel     = bus.req_a[pick_idx*WIDTH +: WIDTH];
    assign b_sel     = bus.req_b[pick_idx*WIDTH +: WIDTH];
    assign accept    = (state == IDLE) && pick_any;
    assign zero_op   = (a_sel == '0) || (b_sel == '0);
    // done may still be high from the previous job during the first RUN cycle
    assign done_seen = (state == RUN) && run_armed && gcd_done;
    assign handshake = (state == RESP) && bus.resp_ready[grant_idx];

`ifdef GCD_TIMEOUT_EN
    localparam int CW = $clog2(MAX_CYCLES) + 1;

    logic [CW-1:0] run_cnt;
    logic          resp_err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_cnt <= '0;
        end else if (state == LOAD) begin
            run_cnt <= '0;
        end else if (state == RUN) begin
            run_cnt <= run_cnt + 1'b1;
        end
    end

    assign timeout = (state == RUN) && !done_seen && (run_cnt == CW'(MAX_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            resp_err_q <= 1'b0;
        end else if (timeout) begin
            resp_err_q <= 1'b1;
        end else if (handshake) begin
            resp_err_q <= 1'b0;
        end
    end

    assign bus.resp_err = resp_err_q;
`else
    assign timeout      = 1'b0;
    assign bus.resp_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (pick_any) state_nxt = zero_op ? RESP : LOAD;
            LOAD: state_nxt = RUN;
            RUN:  if (done_seen || timeout) state_nxt = RESP;
            RESP: if (handshake) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant  <= IW'(NREQ - 1);
            grant_idx   <= '0;
            op_a        <= '0;
            op_b        <= '0;
            resp_data_q <= '0;
            run_armed   <= 1'b0;
        end else begin
            run_armed <= (state == RUN);
            if (accept) begin
                last_grant <= pick_idx;
                grant_idx  <= pick_idx;
                op_a       <= a_sel;
                op_b       <= b_sel;
                // with one operand zero the result is simply the other one
                if (zero_op) resp_data_q <= a_sel | b_sel;
            end else if (done_seen) begin
                resp_data_q <= gcd_out;
            end else if (timeout) begin
                resp_data_q <= '0;
            end
        end
    end

    assign bus.req_ready  = (state == IDLE) ? pick_gnt : '0;
    assign bus.resp_valid = (state == RESP) ? (NREQ'(1) << grant_idx) : '0;
    assign bus.resp_data  = resp_data_q;
    assign busy           = (state != IDLE);
    assign gcd_n1         = op_a;
    assign gcd_n2         = op_b;
    // held high while reset is asserted so the datapath is cleared too
    assign gcd_rst        = (state == LOAD) || !reset;

endmodule

// File: tb/tb_gcd_arbiter.sv
// Scoreboard bench for gcd_arbiter with a behavioural gcd datapath model.
module tb_gcd_arbiter;
    localparam int N    = 4;
    localparam int W    = 32;
    localparam int MAXC = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         busy, gcd_rst, gcd_done;
    logic [W-1:0] gcd_n1, gcd_n2, gcd_out;

    gcd_arbiter_if #(.NREQ(N), .WIDTH(W)) bus ();

    gcd_arbiter #(.NREQ(N), .WIDTH(W), .MAX_CYCLES(MAXC)) dut (
        .clk      (clk),
        .reset    (rst_n),
        .bus      (bus),
        .busy     (busy),
        .gcd_n1   (gcd_n1),
        .gcd_n2   (gcd_n2),
        .gcd_rst  (gcd_rst),
        .gcd_out  (gcd_out),
        .gcd_done (gcd_done)
    );

    always #5 clk = ~clk;

    typedef struct { int unsigned idx; logic [W-1:0] data; logic err; } resp_t;
    typedef struct { logic [W-1:0] a; logic [W-1:0] b; } load_t;

    resp_t       sb[$];
    load_t       lq[$];
    int unsigned exp_last;
    logic [N-1:0] acc = '0;
    int unsigned left[N];
    logic [N-1:0] rr_fixed;
    bit          rr_rand, reuse, force_nodone;
    int          tests = 0, fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] gcd_ref(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    function automatic int unsigned rr_expect(input logic [N-1:0] v, input int unsigned last);
        for (int unsigned k = 1; k <= N; k++)
            if (v[(last + k) % N]) return (last + k) % N;
        return N;
    endfunction

    // Datapath model: done stays stale for one cycle after the load pulse.
    logic [W-1:0] dp_res = '0, dp_pend = '0;
    logic         dp_done = 1'b0, dp_stale = 1'b0;
    int           dp_wait = 0;
    always @(posedge clk) begin
        if (gcd_rst) begin
            dp_pend  <= gcd_ref(gcd_n1, gcd_n2);
            dp_wait  <= 1 + int'($urandom_range(0, 5));
            dp_stale <= 1'b1;
        end else if (dp_stale) begin
            dp_stale <= 1'b0;
            dp_done  <= 1'b0;
            dp_res   <= dp_pend;
        end else if (!dp_done && dp_wait > 0) begin
            dp_wait <= dp_wait - 1;
            if (dp_wait == 1) dp_done <= 1'b1;
        end
    end
    assign gcd_out  = dp_res;
    assign gcd_done = dp_done && !force_nodone;

    // Monitor: grant prediction, load operands and responses against the queues.
    always @(negedge clk) begin : monitor
        int unsigned  gi;
        logic [W-1:0] ga, gb;
        if (!rst_n) begin
            exp_last = N - 1;
            sb.delete();
            lq.delete();
        end else begin
            chk("busy", {63'b0, busy}, {63'b0, sb.size() != 0});
            if (busy) begin
                chk("ready_while_busy", 64'(bus.req_ready), 64'd0);
            end else begin
                chk("ready_any", {63'b0, |bus.req_ready}, {63'b0, |bus.req_valid});
                if (|bus.req_valid) begin
                    gi = rr_expect(bus.req_valid, exp_last);
                    chk("grant", 64'(bus.req_ready), 64'(N'(1) << gi));
                    ga = bus.req_a[gi*W +: W];
                    gb = bus.req_b[gi*W +: W];
                    if (force_nodone && ga != 0 && gb != 0)
                        sb.push_back('{idx: gi, data: '0, err: 1'b1});
                    else
                        sb.push_back('{idx: gi, data: gcd_ref(ga, gb), err: 1'b0});
                    if (ga != 0 && gb != 0) lq.push_back('{a: ga, b: gb});
                    exp_last = gi;
                    acc[gi]  = 1'b1;
                end
            end
            if (gcd_rst) begin
                if (lq.size() == 0) begin
                    chk("spurious_gcd_rst", {63'b0, gcd_rst}, 64'd0);
                end else begin
                    chk("gcd_n1", 64'(gcd_n1), 64'(lq[0].a));
                    chk("gcd_n2", 64'(gcd_n2), 64'(lq[0].b));
                    void'(lq.pop_front());
                end
            end
            if (|bus.resp_valid) begin
                if (sb.size() == 0) begin
                    chk("resp_unexpected", 64'(bus.resp_valid), 64'd0);
                end else begin
                    chk("resp_valid", 64'(bus.resp_valid), 64'(N'(1) << sb[0].idx));
                    chk("resp_data", 64'(bus.resp_data), 64'(sb[0].data));
                    chk("resp_err", {63'b0, bus.resp_err}, {63'b0, sb[0].err});
                    if (bus.resp_ready[sb[0].idx]) void'(sb.pop_front());
                end
            end
        end
    end

    function automatic logic [W-1:0] rnd_op(input logic [W-1:0] k);
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return W'($urandom);
            default: return k * W'($urandom_range(1, 500));
        endcase
    endfunction

    task automatic set_job(input int unsigned i, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.req_a[i*W +: W] = a;
        bus.req_b[i*W +: W] = b;
        bus.req_valid[i]    = 1'b1;
    endtask

    task automatic step();
        logic [W-1:0] k;
        @(posedge clk);
        #1;
        for (int unsigned i = 0; i < N; i++) begin
            if (acc[i]) begin
                acc[i] = 1'b0;
                if (left[i] > 0) begin
                    left[i]--;
                    k = W'($urandom_range(1, 60));
                    if (!reuse) set_job(i, rnd_op(k), rnd_op(k));
                end else begin
                    bus.req_valid[i] = 1'b0;
                end
            end
        end
        bus.resp_ready = rr_rand ? N'($urandom) : rr_fixed;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int c = 0;
        while ((bus.req_valid != 0 || sb.size() != 0 || busy) && c < budget) begin
            step();
            c++;
        end
        chk({tag, "_completes"}, {63'b0, c < budget}, 64'd1);
    endtask

    task automatic check_reset_outputs();
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        chk("rst_resp_data", 64'(bus.resp_data), 64'd0);
        chk("rst_resp_err", {63'b0, bus.resp_err}, 64'd0);
        chk("rst_busy", {63'b0, busy}, 64'd0);
        chk("rst_gcd_n1", 64'(gcd_n1), 64'd0);
        chk("rst_gcd_n2", 64'(gcd_n2), 64'd0);
        chk("rst_gcd_rst", {63'b0, gcd_rst}, 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int c;
        rst_n          = 1'b0;
        bus.req_valid  = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.resp_ready = '1;
        rr_fixed       = '1;
        rr_rand        = 1'b0;
        reuse          = 1'b0;
        force_nodone   = 1'b0;
        for (int unsigned i = 0; i < N; i++) left[i] = 0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();
        rst_n = 1'b1;

        set_job(0, 121, 11);
        wait_idle(100, "single");

        set_job(2, 0, 36);
        wait_idle(100, "zero_b");
        set_job(2, 0, 0);
        wait_idle(100, "zero_zero");

        reuse = 1'b1;
        for (int unsigned i = 0; i < N; i++) begin
            set_job(i, 48, 18);
            left[i] = 1;
        end
        wait_idle(400, "fairness");
        reuse = 1'b0;

        // result held while requester 1 refuses it
        rr_fixed = ~N'(2);
        set_job(1, 35, 49);
        c = 0;
        while (!bus.resp_valid[1] && c < 100) begin
            step();
            c++;
        end
        chk("bp_resp_seen", {63'b0, bus.resp_valid[1]}, 64'd1);
        set_job(0, 27, 18);
        repeat (20) begin
            step();
            chk("bp_hold_valid", 64'(bus.resp_valid), 64'd2);
        end
        rr_fixed = '1;
        wait_idle(100, "backpressure");

        rr_rand = 1'b1;
        for (int unsigned i = 0; i < N; i++) begin
            set_job(i, rnd_op(W'(i + 3)), rnd_op(W'(i + 3)));
            left[i] = $urandom_range(3, 8);
        end
        wait_idle(5000, "random");
        rr_rand = 1'b0;
        bus.resp_ready = '1;

        set_job(3, 1000, 7);
        c = 0;
        while (!gcd_rst && c < 50) begin
            @(negedge clk);
            c++;
        end
        @(posedge clk);
        #2;
        chk("mid_reset_busy", {63'b0, busy}, 64'd1);
        rst_n         = 1'b0;
        bus.req_valid = '0;
        acc           = '0;
        #1;
        check_reset_outputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        set_job(2, 20, 8);
        set_job(0, 9, 3);
        wait_idle(200, "after_reset");

`ifdef GCD_TIMEOUT_EN
        force_nodone = 1'b1;
        set_job(1, 9, 6);
        c = 0;
        while (!gcd_rst && c < 50) begin
            @(negedge clk);
            c++;
        end
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!(|bus.resp_valid) && c < 100);
        chk("timeout_latency", 64'(c), 64'(MAXC + 1));
        wait_idle(100, "timeout");
        force_nodone = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
